// File: rtl/axis_bram_pkg.sv
// Shared definitions for the axis_bram packet path: generator state encoding
// and Galois LFSR tap constants per supported data width.
package axis_bram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } gen_state_t;

    localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

    // Right-shift Galois taps; unsupported widths get no feedback (plain shift).
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            8:       return {24'd0, LFSR_TAPS_8};
            16:      return {16'd0, LFSR_TAPS_16};
            32:      return LFSR_TAPS_32;
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/axis_pkt_gen_pattern.sv
// Pattern word register for axis_pkt_gen: loads the seed, then advances by
// step (incrementing) or by a Galois LFSR when AXIS_PKT_GEN_LFSR_EN is defined.
module axis_pkt_gen_pattern
    import axis_bram_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  advance,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [DATA_WIDTH-1:0] step,
    input  logic                  mode,
    output logic [DATA_WIDTH-1:0] word
);

    logic [DATA_WIDTH-1:0] step_q;
    logic [DATA_WIDTH-1:0] load_val;
    logic [DATA_WIDTH-1:0] word_next;

`ifdef AXIS_PKT_GEN_LFSR_EN
    localparam logic [DATA_WIDTH-1:0] TAPS = DATA_WIDTH'(lfsr_taps(DATA_WIDTH));

    logic                  mode_q;
    logic [DATA_WIDTH-1:0] lfsr_next;

    always_comb begin
        lfsr_next = word >> 1;
        if (word[0]) begin
            lfsr_next = lfsr_next ^ TAPS;
        end
    end

    // An all-zero LFSR state would lock up, so a zero seed becomes all ones.
    assign load_val  = (mode && (seed == '0)) ? '1 : seed;
    assign word_next = mode_q ? lfsr_next : word + step_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= 1'b0;
        end else if (load) begin
            mode_q <= mode;
        end
    end
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign load_val    = seed;
    assign word_next   = word + step_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word   <= '0;
            step_q <= '0;
        end else if (load) begin
            word   <= load_val;
            step_q <= step;
        end else if (advance) begin
            word   <= word_next;
        end
    end

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet source feeding axis_bram; one programmed-length packet per start.
// Optional LFSR pattern mode is built only when AXIS_PKT_GEN_LFSR_EN is defined.
module axis_pkt_gen
    import axis_bram_pkg::*;
#(
    parameter int C_AXIS_BRAM_ADDR_WIDTH = 7,
    parameter int C_AXIS_BRAM_DATA_WIDTH = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                gen_start,
    input  logic [C_AXIS_BRAM_ADDR_WIDTH-1:0]   gen_length,
    input  logic [C_AXIS_BRAM_DATA_WIDTH-1:0]   gen_seed,
    input  logic [C_AXIS_BRAM_DATA_WIDTH-1:0]   gen_step,
    input  logic                                gen_mode,
    output logic                                gen_busy,
    output logic                                gen_done,
    output logic [C_AXIS_BRAM_ADDR_WIDTH-1:0]   gen_beat_cnt,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic [C_AXIS_BRAM_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_BRAM_DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                                m_axis_tlast
);

    localparam int AW = C_AXIS_BRAM_ADDR_WIDTH;
    localparam int DW = C_AXIS_BRAM_DATA_WIDTH;
    localparam int SW = DW / 8;

    gen_state_t state_q, state_d;

    logic [AW:0]   rem_q, rem_d;
    logic [AW:0]   len_eff;
    logic [AW-1:0] cnt_d;
    logic          tvalid_d, tlast_d, busy_d, done_d;
    logic          start_acc;
    logic          hs;

    assign start_acc = (state_q == ST_IDLE) && gen_start;
    assign hs        = m_axis_tvalid && m_axis_tready;
    assign len_eff   = (gen_length == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, gen_length};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (gen_start) state_d = ST_RUN;
            ST_RUN:  if (hs && m_axis_tlast) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead from state_d and registered below.
    always_comb begin
        tvalid_d = (state_d == ST_RUN);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
        tlast_d  = m_axis_tlast;
        rem_d    = rem_q;
        cnt_d    = gen_beat_cnt;
        if (start_acc) begin
            rem_d   = len_eff;
            cnt_d   = '0;
            tlast_d = (len_eff == (AW+1)'(1));
        end else if (hs) begin
            rem_d   = rem_q - (AW+1)'(1);
            cnt_d   = gen_beat_cnt + AW'(1);
            tlast_d = (rem_q == (AW+1)'(2));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tstrb  <= '0;
            gen_busy      <= 1'b0;
            gen_done      <= 1'b0;
            gen_beat_cnt  <= '0;
            rem_q         <= '0;
        end else begin
            m_axis_tvalid <= tvalid_d;
            m_axis_tlast  <= tlast_d;
            m_axis_tstrb  <= {SW{tvalid_d}};
            gen_busy      <= busy_d;
            gen_done      <= done_d;
            gen_beat_cnt  <= cnt_d;
            rem_q         <= rem_d;
        end
    end

    axis_pkt_gen_pattern #(
        .DATA_WIDTH (DW)
    ) u_pattern (
        .clk     (clk),
        .reset   (reset),
        .load    (start_acc),
        .advance (hs),
        .seed    (gen_seed),
        .step    (gen_step),
        .mode    (gen_mode),
        .word    (m_axis_tdata)
    );

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Randomized self-checking bench for axis_pkt_gen against a per-beat pattern model.
module tb_axis_pkt_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       gen_start = 1'b0;
    logic [6:0] gen_length = '0;
    logic [7:0] gen_seed = '0;
    logic [7:0] gen_step = '0;
    logic       gen_mode = 1'b0;
    logic       gen_busy, gen_done;
    logic [6:0] gen_beat_cnt;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b0;
    logic [7:0] m_axis_tdata;
    logic [0:0] m_axis_tstrb;
    logic       m_axis_tlast;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axis_pkt_gen dut (
        .clk           (clk),
        .reset         (reset),
        .gen_start     (gen_start),
        .gen_length    (gen_length),
        .gen_seed      (gen_seed),
        .gen_step      (gen_step),
        .gen_mode      (gen_mode),
        .gen_busy      (gen_busy),
        .gen_done      (gen_done),
        .gen_beat_cnt  (gen_beat_cnt),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tlast  (m_axis_tlast)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Beat i of a packet, from the pattern rules directly.
    function automatic logic [7:0] exp_word(input bit mode, input logic [7:0] seed,
                                            input logic [7:0] step, input int i);
        logic [7:0] w;
`ifdef AXIS_PKT_GEN_LFSR_EN
        if (mode) begin
            w = (seed == 8'h00) ? 8'hFF : seed;
            for (int k = 0; k < i; k++) begin
                w = w[0] ? ((w >> 1) ^ 8'hB8) : (w >> 1);
            end
            return w;
        end
`endif
        w = 8'((int'(seed) + i * int'(step)) % 256);
        return w;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
        chk({tag, "_tlast"},  32'(m_axis_tlast),  32'd0);
        chk({tag, "_tstrb"},  32'(m_axis_tstrb),  32'd0);
        chk({tag, "_busy"},   32'(gen_busy),      32'd0);
        chk({tag, "_done"},   32'(gen_done),      32'd0);
    endtask

    // stall: 0 = ready always, 1 = toggle 1,0,1,0..., 2 = random
    task automatic send(input int len, input logic [7:0] seed, input logic [7:0] step,
                        input bit mode, input int stall, input bit mid_start, input bit done_start);
        int L, idx, k;
        bit rdy;
        L = (len == 0) ? 128 : len;
        gen_length = 7'(len);
        gen_seed   = seed;
        gen_step   = step;
        gen_mode   = mode;
        gen_start  = 1'b1;
        @(negedge clk);
        gen_start  = 1'b0;
        gen_length = 7'($urandom_range(1, 127));
        gen_seed   = 8'($urandom);
        gen_step   = 8'($urandom);
        gen_mode   = 1'($urandom);
        idx = 0;
        k = 0;
        while (idx < L) begin
            if (k > 4 * L + 20) begin
                chk("beat_timeout", 32'(idx), 32'(L));
                break;
            end
            chk("tvalid", 32'(m_axis_tvalid), 32'd1);
            chk("tdata",  32'(m_axis_tdata),  32'(exp_word(mode, seed, step, idx)));
            chk("tlast",  32'(m_axis_tlast),  32'(idx == L - 1));
            chk("tstrb",  32'(m_axis_tstrb),  32'd1);
            chk("beat_cnt", 32'(gen_beat_cnt), 32'(idx % 128));
            chk("busy",   32'(gen_busy),      32'd1);
            case (stall)
                0:       rdy = 1'b1;
                1:       rdy = (k % 2 == 0);
                default: rdy = 1'($urandom);
            endcase
            m_axis_tready = rdy;
            gen_start = mid_start && (k == 1);
            @(negedge clk);
            gen_start = 1'b0;
            if (rdy) idx++;
            k++;
        end
        m_axis_tready = 1'($urandom);
        chk("done_pulse", 32'(gen_done), 32'd1);
        chk("done_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("done_busy", 32'(gen_busy), 32'd1);
        chk("done_cnt", 32'(gen_beat_cnt), 32'(L % 128));
        gen_start = done_start;
        @(negedge clk);
        gen_start = 1'b0;
        check_idle_outputs("idle");
        chk("idle_cnt", 32'(gen_beat_cnt), 32'(L % 128));
    endtask

    initial begin
        #1;
        check_idle_outputs("reset");
        chk("reset_tdata", 32'(m_axis_tdata), 32'd0);
        chk("reset_cnt", 32'(gen_beat_cnt), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        send(4, 8'h04, 8'h01, 1'b0, 0, 1'b0, 1'b0);
        send(3, 8'hFE, 8'h01, 1'b0, 1, 1'b0, 1'b0);
        send(0, 8'h20, 8'h03, 1'b0, 0, 1'b0, 1'b0);
        send(5, 8'h11, 8'h22, 1'b0, 2, 1'b1, 1'b1);
        send(1, 8'h7F, 8'h05, 1'b0, 1, 1'b0, 1'b1);
        send(2, 8'hF0, 8'h10, 1'b0, 0, 1'b0, 1'b0);

        // Abandon a packet after two beats with an async reset.
        gen_length = 7'd8;
        gen_seed   = 8'h10;
        gen_step   = 8'h03;
        gen_mode   = 1'b0;
        gen_start  = 1'b1;
        @(negedge clk);
        gen_start = 1'b0;
        m_axis_tready = 1'b1;
        repeat (2) @(negedge clk);
        chk("pre_rst_tdata", 32'(m_axis_tdata), 32'h16);
        reset = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        chk("async_rst_tdata", 32'(m_axis_tdata), 32'd0);
        chk("async_rst_cnt", 32'(gen_beat_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_axis_tready = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_rst");
        send(8, 8'h10, 8'h03, 1'b0, 0, 1'b0, 1'b0);

`ifdef AXIS_PKT_GEN_LFSR_EN
        send(3, 8'h01, 8'h55, 1'b1, 0, 1'b0, 1'b0);
        send(6, 8'h00, 8'h01, 1'b1, 2, 1'b1, 1'b0);
`else
        send(3, 8'h01, 8'h02, 1'b1, 0, 1'b0, 1'b0);
`endif

        for (int p = 0; p < 10; p++) begin
            send(int'($urandom_range(0, 24)), 8'($urandom), 8'($urandom), 1'($urandom),
                 int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

endmodule
